// File: rtl/avg_seq_ctrl_if.sv
// avg_seq_ctrl_if
//   Sample-in / result-out handshake bundle for avg_seq_ctrl.
//   master : sample producer + result consumer (drives in_*, sa, avg_ready)
//   slave  : the averaging block (drives in_ready, avg_valid, avg)
// Signals:
//   in_valid/in_ready/in_data : sample handshake, unsigned WIDTH-bit sample
//   sa                        : shift amount, taken with first sample of a batch
//   avg_valid/avg_ready/avg   : result handshake, WIDTH-bit result
interface avg_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       sa;
  logic             avg_valid;
  logic             avg_ready;
  logic [WIDTH-1:0] avg;

  modport master (
    output in_valid, in_data, sa, avg_ready,
    input  in_ready, avg_valid, avg
  );

  modport slave (
    input  in_valid, in_data, sa, avg_ready,
    output in_ready, avg_valid, avg
  );
endinterface

// File: rtl/avg_seq_ctrl.sv
// avg_seq_ctrl
//   Accumulates a batch of 8 unsigned samples, then shifts the sum right by
//   the batch's shift amount three times, one shift per cycle, and presents
//   the WIDTH LSBs as the result. A single adder is shared between
//   accumulation and (optionally) rounding; a single shifter does all shifts.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (wins over clr_i and handshakes)
//   clr_i   : synchronous abort back to IDLE, drops any sample in flight
//   bus     : avg_seq_ctrl_if.slave (sample in, result out)
//   count_o : samples accepted in the current batch (0..8)
//   busy_o  : high whenever not IDLE
// Build option:
//   AVG_SEQ_ROUND_EN : when defined, each shift with 1 <= sa < ACC_WIDTH rounds
//                      half up; otherwise shifts truncate.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for first sample, latches sa on it
// S_ACCUM | accepting samples 2..8 into the accumulator
// S_SHIFT | three single-cycle shifts of the accumulator
// S_DONE  | result presented until consumer takes it
module avg_seq_ctrl #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  avg_seq_ctrl_if.slave       bus,
  output logic [3:0]          count_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SHIFT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [1:0]             step_q, step_d;
  logic [7:0]             sa_q, sa_d;

  logic                   xfer;
  logic [ACC_WIDTH-1:0]   data_ext;
  logic [ACC_WIDTH-1:0]   round_inc;
  logic [ACC_WIDTH-1:0]   add_b;
  logic [ACC_WIDTH:0]     add_sum;
  logic [ACC_WIDTH-1:0]   shift_res;
  logic                   sa_big;

  assign data_ext = ACC_WIDTH'(bus.in_data);
  assign sa_big   = (32'(sa_q) >= ACC_WIDTH);

`ifdef AVG_SEQ_ROUND_EN
  // Half-LSB of the shifted result; zero for sa = 0 and for sa that clears acc.
  always_comb begin
    round_inc = '0;
    if (sa_q != 8'd0 && !sa_big)
      round_inc = ACC_WIDTH'(1) << (sa_q - 8'd1);
  end
`else
  assign round_inc = '0;
`endif

  // Shared adder: sample accumulation in ACCUM, rounding increment in SHIFT.
  // One extra bit keeps the carry of acc + round_inc ahead of the shift.
  assign add_b     = (state_q == S_SHIFT) ? round_inc : data_ext;
  assign add_sum   = {1'b0, acc_q} + {1'b0, add_b};
  assign shift_res = sa_big ? '0 : ACC_WIDTH'(add_sum >> sa_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      sa_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sa_q    <= sa_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    sa_d          = sa_q;
    bus.in_ready  = 1'b0;
    bus.avg_valid = 1'b0;
    bus.avg       = '0;
    busy_o        = 1'b1;
    xfer          = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy_o       = 1'b0;
        xfer         = bus.in_valid;
        if (xfer) begin
          acc_d   = data_ext;
          sa_d    = bus.sa;
          cnt_d   = 4'd1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        xfer         = bus.in_valid;
        if (xfer) begin
          acc_d = add_sum[ACC_WIDTH-1:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = S_SHIFT;
            step_d  = 2'd0;
          end
        end
      end
      S_SHIFT: begin
        acc_d  = shift_res;
        step_d = step_q + 2'd1;
        if (step_q == 2'd2)
          state_d = S_DONE;
      end
      S_DONE: begin
        bus.avg_valid = 1'b1;
        bus.avg       = acc_q[WIDTH-1:0];
        if (bus.avg_ready) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: any transfer this cycle is dropped along with the batch.
    if (clr_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      step_d  = '0;
      sa_d    = '0;
    end
  end

  assign count_o = cnt_q;

endmodule
